bp_host_mmio_mux: RTL and testbench

- Multi-channel host MMIO responder; next generation of the single-port nonsynth host.
- Sits between num_chan_p I/O command sources (per-core or per-tile I/O ports) and host-side character streams.
- Serves getchar, putchar, per-core finish, a parametrised enable bank and a status word, one transaction at a time under round-robin arbitration.
- Adds: configurable response latency, error responses, sticky pass/fail per core, no-traffic watchdog.

---
 rtl/bp_host_mmio_mux_if.sv | 29 ++
 rtl/bp_host_mmio_mux.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_bp_host_mmio_mux.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bp_host_mmio_mux_if.sv
// rtl/bp_host_mmio_mux_if.sv - per-channel MMIO command/response bundle
//   master: command source (drives cmd_*, resp_yumi)
//   slave : responder      (drives cmd_ready_and, resp_*)
//   Vectors are packed channel-major: channel c occupies [c*w +: w].
interface bp_host_mmio_mux_if #(
    parameter int num_chan_p   = 2,
    parameter int addr_width_p = 40,
    parameter int data_width_p = 64
);
    logic [num_chan_p-1:0]              cmd_v;
    logic [num_chan_p-1:0]              cmd_ready_and;
    logic [num_chan_p*addr_width_p-1:0] cmd_addr;
    logic [num_chan_p-1:0]              cmd_we;
    logic [num_chan_p*data_width_p-1:0] cmd_data;
    logic [num_chan_p-1:0]              resp_v;
    logic [num_chan_p-1:0]              resp_yumi;
    logic [num_chan_p*data_width_p-1:0] resp_data;
    logic [num_chan_p-1:0]              resp_err;

    modport master (
        output cmd_v, cmd_addr, cmd_we, cmd_data, resp_yumi,
        input  cmd_ready_and, resp_v, resp_data, resp_err
    );

    modport slave (
        input  cmd_v, cmd_addr, cmd_we, cmd_data, resp_yumi,
        output cmd_ready_and, resp_v, resp_data, resp_err
    );
endinterface

// File: rtl/bp_host_mmio_mux.sv
// rtl/bp_host_mmio_mux.sv - multi-channel host MMIO responder (getchar/putchar/finish/enables/status)
//   clk_i, reset_n_i        : clock, asynchronous active-low reset
//   bus (slave)             : per-channel command/response handshakes
//   char_v_o/data/core      : putchar stream out, char_ready_and_i from sink
//   getchar_v_i/data        : input characters into a small FIFO, getchar_ready_and_o = not full
//   en_o                    : enable register bank
//   finish_o, fail_o        : sticky per-core finish and pass/fail
//   all_finished_o          : every core has finished
//   timeout_o               : sticky no-traffic watchdog
module bp_host_mmio_mux #(
    parameter int num_chan_p       = 2,
    parameter int addr_width_p     = 40,
    parameter int data_width_p     = 64,
    parameter int num_core_p       = 4,
    parameter int num_en_p         = 16,
    parameter int fifo_els_p       = 4,
    parameter int resp_latency_p   = 2,
    parameter int timeout_cycles_p = 1024,
    localparam int core_w_lp       = (num_core_p > 1) ? $clog2(num_core_p) : 1
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    bp_host_mmio_mux_if.slave     bus,
    output logic                  char_v_o,
    output logic [7:0]            char_data_o,
    output logic [core_w_lp-1:0]  char_core_o,
    input  logic                  char_ready_and_i,
    input  logic                  getchar_v_i,
    input  logic [7:0]            getchar_data_i,
    output logic                  getchar_ready_and_o,
    output logic [num_en_p-1:0]   en_o,
    output logic [num_core_p-1:0] finish_o,
    output logic [num_core_p-1:0] fail_o,
    output logic                  all_finished_o,
    output logic                  timeout_o
);
    localparam int chan_w_lp = (num_chan_p > 1) ? $clog2(num_chan_p) : 1;
    localparam int en_w_lp   = (num_en_p > 1) ? $clog2(num_en_p) : 1;
    localparam int idx_w_lp  = (core_w_lp > en_w_lp) ? core_w_lp : en_w_lp;
    localparam int lat_w_lp  = (resp_latency_p > 0) ? $clog2(resp_latency_p + 1) : 1;
    localparam int ptr_w_lp  = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;
    localparam int cnt_w_lp  = $clog2(fifo_els_p + 1);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DELAY, S_RESP} state_e;
    typedef enum logic [2:0] {
        OP_GETC, OP_PUTC, OP_FIN, OP_PUTCC, OP_ENW, OP_ENR, OP_STAT, OP_ERR
    } op_e;

    state_e                 state_r;
    logic [chan_w_lp-1:0]   rr_r;
    logic [chan_w_lp-1:0]   ch_r;
    op_e                    op_r;
    logic [idx_w_lp-1:0]    idx_r;
    logic [7:0]             wdat_r;
    logic                   char_v_r;
    logic [core_w_lp-1:0]   char_core_r;
    logic [lat_w_lp-1:0]    lat_cnt_r;
    logic [data_width_p-1:0] resp_data_r;
    logic                   resp_err_r;
    logic [num_en_p-1:0]    en_r;
    logic [num_core_p-1:0]  finish_r;
    logic [num_core_p-1:0]  fail_r;
    logic                   timeout_r;

    // Round-robin grant: scan downward so the lowest offset from rr_r wins.
    logic                 grant_v;
    logic [chan_w_lp-1:0] grant;
    always_comb begin
        int j;
        grant_v = 1'b0;
        grant   = '0;
        for (int i = num_chan_p - 1; i >= 0; i--) begin
            j = int'(rr_r) + i;
            if (j >= num_chan_p) j = j - num_chan_p;
            if (bus.cmd_v[chan_w_lp'(j)]) begin
                grant_v = 1'b1;
                grant   = chan_w_lp'(j);
            end
        end
    end

    wire accept = (state_r == S_IDLE) && grant_v;

    always_comb begin
        bus.cmd_ready_and = '0;
        if (accept) bus.cmd_ready_and[grant] = 1'b1;
    end

    // Decode the granted command at accept so EXEC only acts on registers.
    logic [addr_width_p-1:0] sel_addr;
    logic                    sel_we;
    logic [7:0]              sel_data;
    logic [19:0]             off;
    logic [8:0]              widx;
    logic                    aligned, core_ok, en_ok, page_exact;
    op_e                     dec_op;

    assign sel_addr   = bus.cmd_addr[grant*addr_width_p +: addr_width_p];
    assign sel_we     = bus.cmd_we[grant];
    assign sel_data   = bus.cmd_data[grant*data_width_p +: 8];
    assign off        = sel_addr[19:0];
    assign widx       = off[11:3];
    assign aligned    = (off[2:0] == 3'b000);
    assign page_exact = (off[11:0] == 12'h000);
    assign core_ok    = ({1'b0, widx} < 10'(num_core_p));
    assign en_ok      = ({1'b0, widx} < 10'(num_en_p));

    always_comb begin
        dec_op = OP_ERR;
        if (sel_addr[addr_width_p-1:20] == '0) begin
            case (off[19:12])
                8'h00:   if (page_exact && !sel_we) dec_op = OP_GETC;
                8'h01:   if (page_exact && sel_we) dec_op = OP_PUTC;
                8'h02:   if (aligned && core_ok && sel_we) dec_op = OP_FIN;
                8'h03:   if (aligned && core_ok && sel_we) dec_op = OP_PUTCC;
                8'h04:   if (aligned && en_ok) dec_op = sel_we ? OP_ENW : OP_ENR;
                8'h05:   if (page_exact && !sel_we) dec_op = OP_STAT;
                default: dec_op = OP_ERR;
            endcase
        end
    end

    // getchar FIFO
    logic [7:0]          fifo_mem [fifo_els_p];
    logic [ptr_w_lp-1:0] rd_ptr_r, wr_ptr_r;
    logic [cnt_w_lp-1:0] count_r;
    logic                fifo_empty, fifo_full, fifo_push, fifo_pop;

    assign fifo_empty = (count_r == '0);
    assign fifo_full  = (count_r == cnt_w_lp'(fifo_els_p));
    assign fifo_push  = getchar_v_i && !fifo_full;
    // Only the FIFO state before this edge matters: a char arriving in the
    // same cycle as an empty-FIFO read is not returned.
    assign fifo_pop   = (state_r == S_EXEC) && (op_r == OP_GETC) && !fifo_empty;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (fifo_push)
                wr_ptr_r <= (wr_ptr_r == ptr_w_lp'(fifo_els_p - 1)) ? '0 : wr_ptr_r + ptr_w_lp'(1);
            if (fifo_pop)
                rd_ptr_r <= (rd_ptr_r == ptr_w_lp'(fifo_els_p - 1)) ? '0 : rd_ptr_r + ptr_w_lp'(1);
            if (fifo_push && !fifo_pop)
                count_r <= count_r + cnt_w_lp'(1);
            else if (!fifo_push && fifo_pop)
                count_r <= count_r - cnt_w_lp'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (fifo_push) fifo_mem[wr_ptr_r] <= getchar_data_i;
    end

    // Response data produced in EXEC
    logic [2*num_core_p+1:0]  status;
    logic [data_width_p-1:0]  exec_data;
    logic                     exec_err;

    assign status = {timeout_r, &finish_r, fail_r, finish_r};

    always_comb begin
        exec_data = '0;
        exec_err  = 1'b0;
        case (op_r)
            OP_GETC: exec_data = fifo_empty ? '1
                               : {{(data_width_p-8){1'b0}}, fifo_mem[rd_ptr_r]};
            OP_ENR:  exec_data = data_width_p'(en_r[idx_r[en_w_lp-1:0]]);
            OP_STAT: exec_data = data_width_p'(status);
            OP_ERR:  exec_err  = 1'b1;
            default: exec_data = '0;
        endcase
    end

    // Main FSM
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r     <= S_IDLE;
            rr_r        <= '0;
            ch_r        <= '0;
            op_r        <= OP_ERR;
            idx_r       <= '0;
            wdat_r      <= '0;
            char_v_r    <= 1'b0;
            char_core_r <= '0;
            lat_cnt_r   <= '0;
            resp_data_r <= '0;
            resp_err_r  <= 1'b0;
            en_r        <= '0;
            finish_r    <= '0;
            fail_r      <= '0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (grant_v) begin
                        ch_r        <= grant;
                        rr_r        <= (grant == chan_w_lp'(num_chan_p - 1)) ? '0
                                     : grant + chan_w_lp'(1);
                        op_r        <= dec_op;
                        idx_r       <= widx[idx_w_lp-1:0];
                        wdat_r      <= sel_data;
                        char_v_r    <= (dec_op == OP_PUTC) || (dec_op == OP_PUTCC);
                        char_core_r <= (dec_op == OP_PUTCC) ? widx[core_w_lp-1:0] : '0;
                        state_r     <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    // A putchar waits here until the sink takes the character.
                    if (!(char_v_r && !char_ready_and_i)) begin
                        char_v_r    <= 1'b0;
                        resp_data_r <= exec_data;
                        resp_err_r  <= exec_err;
                        case (op_r)
                            OP_FIN: if (!finish_r[idx_r[core_w_lp-1:0]]) begin
                                finish_r[idx_r[core_w_lp-1:0]] <= 1'b1;
                                fail_r[idx_r[core_w_lp-1:0]]   <= wdat_r[0];
                            end
                            OP_ENW:  en_r[idx_r[en_w_lp-1:0]] <= wdat_r[0];
                            default: ;
                        endcase
                        lat_cnt_r <= lat_w_lp'(resp_latency_p - 1);
                        state_r   <= (resp_latency_p == 0) ? S_RESP : S_DELAY;
                    end
                end
                S_DELAY: begin
                    if (lat_cnt_r == '0) state_r <= S_RESP;
                    else                 lat_cnt_r <= lat_cnt_r - lat_w_lp'(1);
                end
                S_RESP: begin
                    if (bus.resp_yumi[ch_r]) state_r <= S_IDLE;
                end
                default: state_r <= S_IDLE;
            endcase
        end
    end

    // Watchdog
    generate
        if (timeout_cycles_p > 0) begin : g_wd
            localparam int wd_w_lp = $clog2(timeout_cycles_p + 1);
            logic [wd_w_lp-1:0] wd_cnt_r;
            always_ff @(posedge clk_i or negedge reset_n_i) begin
                if (!reset_n_i) begin
                    wd_cnt_r  <= '0;
                    timeout_r <= 1'b0;
                end else if (!timeout_r) begin
                    if (accept) begin
                        wd_cnt_r <= '0;
                    end else if (wd_cnt_r == wd_w_lp'(timeout_cycles_p - 1)) begin
                        wd_cnt_r  <= wd_w_lp'(timeout_cycles_p);
                        timeout_r <= 1'b1;
                    end else begin
                        wd_cnt_r <= wd_cnt_r + wd_w_lp'(1);
                    end
                end
            end
        end else begin : g_no_wd
            assign timeout_r = 1'b0;
        end
    endgenerate

    // Outputs
    always_comb begin
        bus.resp_v = '0;
        if (state_r == S_RESP) bus.resp_v[ch_r] = 1'b1;
    end
    assign bus.resp_data = {num_chan_p{resp_data_r}};
    assign bus.resp_err  = bus.resp_v & {num_chan_p{resp_err_r}};

    assign char_v_o            = char_v_r;
    assign char_data_o         = wdat_r;
    assign char_core_o         = char_core_r;
    assign getchar_ready_and_o = !fifo_full;
    assign en_o                = en_r;
    assign finish_o            = finish_r;
    assign fail_o              = fail_r;
    assign all_finished_o      = &finish_r;
    assign timeout_o           = timeout_r;
endmodule

// File: tb/tb_bp_host_mmio_mux.sv
// tb/tb_bp_host_mmio_mux.sv - scoreboard testbench for bp_host_mmio_mux
module tb_bp_host_mmio_mux;
    localparam int NC = 2, AW = 40, DW = 64, NCORE = 4, NEN = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, rst_wd_n;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bp_host_mmio_mux_if #(.num_chan_p(NC), .addr_width_p(AW), .data_width_p(DW)) bus ();
    bp_host_mmio_mux_if #(.num_chan_p(NC), .addr_width_p(AW), .data_width_p(DW)) bus_wd ();

    logic          ch_v    [NC];
    logic [AW-1:0] ch_addr [NC];
    logic          ch_we   [NC];
    logic [DW-1:0] ch_data [NC];
    logic          ch_yumi [NC];

    for (genvar g = 0; g < NC; g++) begin : g_drv
        assign bus.cmd_v[g]              = ch_v[g];
        assign bus.cmd_addr[g*AW +: AW]  = ch_addr[g];
        assign bus.cmd_we[g]             = ch_we[g];
        assign bus.cmd_data[g*DW +: DW]  = ch_data[g];
        assign bus.resp_yumi[g]          = ch_yumi[g];
    end
    assign bus_wd.cmd_v     = '0;
    assign bus_wd.cmd_addr  = '0;
    assign bus_wd.cmd_we    = '0;
    assign bus_wd.cmd_data  = '0;
    assign bus_wd.resp_yumi = '1;

    logic             char_v, char_ready, getchar_v, getchar_ready, all_fin, timeout;
    logic [7:0]       char_data, getchar_data;
    logic [1:0]       char_core;
    logic [NEN-1:0]   en;
    logic [NCORE-1:0] finish, fail;

    logic             wd_char_v, wd_getchar_ready, wd_all_fin, wd_timeout;
    logic [7:0]       wd_char_data;
    logic [1:0]       wd_char_core;
    logic [NEN-1:0]   wd_en;
    logic [NCORE-1:0] wd_finish, wd_fail;

    bp_host_mmio_mux #(
        .num_chan_p(NC), .addr_width_p(AW), .data_width_p(DW), .num_core_p(NCORE),
        .num_en_p(NEN), .fifo_els_p(4), .resp_latency_p(2), .timeout_cycles_p(1024)
    ) dut (
        .clk_i(clk), .reset_n_i(rst_n), .bus(bus),
        .char_v_o(char_v), .char_data_o(char_data), .char_core_o(char_core),
        .char_ready_and_i(char_ready), .getchar_v_i(getchar_v), .getchar_data_i(getchar_data),
        .getchar_ready_and_o(getchar_ready), .en_o(en), .finish_o(finish), .fail_o(fail),
        .all_finished_o(all_fin), .timeout_o(timeout)
    );

    bp_host_mmio_mux #(
        .num_chan_p(NC), .addr_width_p(AW), .data_width_p(DW), .num_core_p(NCORE),
        .num_en_p(NEN), .fifo_els_p(4), .resp_latency_p(2), .timeout_cycles_p(8)
    ) dut_wd (
        .clk_i(clk), .reset_n_i(rst_wd_n), .bus(bus_wd),
        .char_v_o(wd_char_v), .char_data_o(wd_char_data), .char_core_o(wd_char_core),
        .char_ready_and_i(1'b1), .getchar_v_i(1'b0), .getchar_data_i(8'h00),
        .getchar_ready_and_o(wd_getchar_ready), .en_o(wd_en), .finish_o(wd_finish),
        .fail_o(wd_fail), .all_finished_o(wd_all_fin), .timeout_o(wd_timeout)
    );

    typedef struct {
        int            ch;
        logic [DW-1:0] data;
        logic          err;
        int            t0;
        int            lat;
    } exp_t;

    exp_t sb[$];
    int   glog[$];
    bit   log_en = 1'b0;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, expv);
        end
    endtask

    // Monitor: compares every response handshake against the scoreboard head.
    initial begin
        exp_t e;
        logic [DW-1:0] got;
        forever begin
            @(negedge clk);
            #4;
            for (int c = 0; c < NC; c++) begin
                if (rst_n && bus.resp_v[c] && ch_yumi[c]) begin
                    got = bus.resp_data[c*DW +: DW];
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_resp: ch%0d data %h err %b", c, got, bus.resp_err[c]);
                    end else begin
                        e = sb.pop_front();
                        if (e.ch != c || got !== e.data || bus.resp_err[c] !== e.err
                            || (e.lat >= 0 && cyc - e.t0 != e.lat)) begin
                            errors++;
                            $display("FAIL resp: got ch%0d data %h err %b lat %0d, expected ch%0d data %h err %b lat %0d",
                                     c, got, bus.resp_err[c], cyc - e.t0, e.ch, e.data, e.err, e.lat);
                        end
                    end
                end
            end
        end
    end

    // Grant logger
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (log_en)
                for (int c = 0; c < NC; c++)
                    if (ch_v[c] && bus.cmd_ready_and[c]) glog.push_back(c);
        end
    end

    // Issue one command; called and returns on a negedge.
    task automatic issue(input int ch, input logic [AW-1:0] a, input logic we,
                         input logic [DW-1:0] d, input bit push,
                         input logic [DW-1:0] ed, input logic ee, input int lat);
        exp_t e;
        bit   acc = 1'b0;
        ch_v[ch] = 1'b1; ch_addr[ch] = a; ch_we[ch] = we; ch_data[ch] = d;
        for (int i = 0; i < 60 && !acc; i++) begin
            #4;
            if (bus.cmd_ready_and[ch]) begin
                acc = 1'b1;
                if (push) begin
                    e.ch = ch; e.data = ed; e.err = ee; e.t0 = cyc; e.lat = lat;
                    sb.push_back(e);
                end
            end
            @(negedge clk);
        end
        ch_v[ch] = 1'b0;
        if (!acc) begin
            checks++; errors++;
            $display("FAIL accept_timeout: ch%0d addr %h not accepted", ch, a);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout: %0d responses outstanding, expected 0", sb.size());
        end
        @(negedge clk);
    endtask

    task automatic gpush(input logic [7:0] c);
        getchar_v = 1'b1; getchar_data = c;
        @(negedge clk);
        getchar_v = 1'b0;
    endtask

    localparam logic [DW-1:0] ONES = '1;

    initial begin
        bit seen;
        rst_n = 1'b0; rst_wd_n = 1'b0;
        char_ready = 1'b1; getchar_v = 1'b0; getchar_data = 8'h00;
        for (int c = 0; c < NC; c++) begin
            ch_v[c] = 1'b0; ch_addr[c] = '0; ch_we[c] = 1'b0; ch_data[c] = '0; ch_yumi[c] = 1'b1;
        end
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_resp_v", 64'(bus.resp_v), 64'h0);
        chk("rst_cmd_ready", 64'(bus.cmd_ready_and), 64'h0);
        chk("rst_char_v", 64'(char_v), 64'h0);
        chk("rst_getchar_ready", 64'(getchar_ready), 64'h1);
        chk("rst_flags", 64'({en, finish, fail, all_fin, timeout}), 64'h0);
        chk("rst_wd_timeout", 64'(wd_timeout), 64'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Status read, minimum latency 2+2
        issue(0, 40'h05000, 1'b0, '0, 1'b1, '0, 1'b0, 4);
        drain();

        // Round-robin with both channels busy
        glog.delete();
        log_en = 1'b1;
        fork
            begin for (int i = 0; i < 4; i++) issue(0, 40'h05000, 1'b0, '0, 1'b1, '0, 1'b0, -1); end
            begin for (int i = 0; i < 4; i++) issue(1, 40'h05000, 1'b0, '0, 1'b1, '0, 1'b0, -1); end
        join
        log_en = 1'b0;
        drain();
        chk("grant_count", 64'(glog.size()), 64'd8);
        if (glog.size() == 8) begin
            chk("grant_first", 64'(glog[0]), 64'd1);
            for (int i = 1; i < 8; i++) begin
                checks++;
                if (glog[i] == glog[i-1]) begin
                    errors++;
                    $display("FAIL grant_alternate: grant %0d repeats ch%0d", i, glog[i]);
                end
            end
        end

        // Enable bank
        issue(1, 40'h04028, 1'b1, 64'h1, 1'b1, '0, 1'b0, -1);
        issue(1, 40'h04078, 1'b1, 64'h3, 1'b1, '0, 1'b0, -1);
        issue(1, 40'h04080, 1'b1, 64'h1, 1'b1, '0, 1'b1, -1);
        issue(0, 40'h04028, 1'b0, '0, 1'b1, 64'h1, 1'b0, -1);
        issue(0, 40'h04030, 1'b0, '0, 1'b1, 64'h0, 1'b0, -1);
        drain();
        chk("en_bank", 64'(en), 64'h8020);

        // Error decodes
        issue(0, 40'h06000, 1'b0, '0, 1'b1, '0, 1'b1, -1);
        issue(0, 40'h00000, 1'b1, 64'h55, 1'b1, '0, 1'b1, -1);
        issue(1, 40'h01000, 1'b0, '0, 1'b1, '0, 1'b1, -1);
        issue(1, 40'h102000, 1'b1, 64'h1, 1'b1, '0, 1'b1, -1);
        issue(0, 40'h02020, 1'b1, 64'h1, 1'b1, '0, 1'b1, -1);
        issue(0, 40'h02004, 1'b1, 64'h1, 1'b1, '0, 1'b1, -1);
        drain();
        chk("err_no_side_effect", 64'({en, finish, fail}), 64'h8020_00);
        chk("err_no_char", 64'(char_v), 64'h0);

        // Tagged putchar with a stalled sink
        char_ready = 1'b0;
        issue(0, 40'h03010, 1'b1, 64'h41, 1'b0, '0, 1'b0, -1);
        for (int i = 0; i < 5; i++) begin
            chk("putc_stall", 64'({char_v, char_data, char_core}), 64'({1'b1, 8'h41, 2'd2}));
            @(negedge clk);
        end
        char_ready = 1'b1;
        begin
            exp_t e;
            e.ch = 0; e.data = '0; e.err = 1'b0; e.t0 = cyc; e.lat = 3;
            sb.push_back(e);
        end
        @(negedge clk);
        chk("putc_done", 64'(char_v), 64'h0);
        drain();

        // Global putchar
        issue(1, 40'h01000, 1'b1, 64'h15A, 1'b1, '0, 1'b0, -1);
        chk("putc_global", 64'({char_v, char_data, char_core}), 64'({1'b1, 8'h5A, 2'd0}));
        drain();

        // getchar
        gpush(8'h61);
        gpush(8'h62);
        issue(1, 40'h00000, 1'b0, '0, 1'b1, 64'h61, 1'b0, -1);
        issue(1, 40'h00000, 1'b0, '0, 1'b1, 64'h62, 1'b0, -1);
        issue(1, 40'h00000, 1'b0, '0, 1'b1, ONES, 1'b0, -1);
        drain();
        for (int i = 0; i < 4; i++) begin
            chk("fifo_ready_before", 64'(getchar_ready), 64'h1);
            gpush(8'(8'h31 + i));
        end
        chk("fifo_full", 64'(getchar_ready), 64'h0);
        gpush(8'h35);
        chk("fifo_still_full", 64'(getchar_ready), 64'h0);
        for (int i = 0; i < 4; i++)
            issue(0, 40'h00000, 1'b0, '0, 1'b1, 64'(8'h31 + i), 1'b0, -1);
        issue(0, 40'h00000, 1'b0, '0, 1'b1, ONES, 1'b0, -1);
        drain();

        // Finish / fail
        issue(0, 40'h02000, 1'b1, 64'h0, 1'b1, '0, 1'b0, -1);
        issue(0, 40'h02008, 1'b1, 64'h1, 1'b1, '0, 1'b0, -1);
        issue(0, 40'h02008, 1'b1, 64'h0, 1'b1, '0, 1'b0, -1);
        issue(0, 40'h02010, 1'b1, 64'h0, 1'b1, '0, 1'b0, -1);
        drain();
        chk("not_all_finished", 64'(all_fin), 64'h0);
        issue(0, 40'h02018, 1'b1, 64'h0, 1'b1, '0, 1'b0, -1);
        drain();
        chk("finish_vec", 64'({finish, fail, all_fin}), 64'({4'hF, 4'h2, 1'b1}));
        issue(1, 40'h05000, 1'b0, '0, 1'b1, 64'h12F, 1'b0, -1);
        drain();

        // Response held until consumed
        ch_yumi[0] = 1'b0;
        issue(0, 40'h04028, 1'b0, '0, 1'b1, 64'h1, 1'b0, -1);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (bus.resp_v[0]) seen = 1'b1;
            else @(negedge clk);
        end
        chk("hold_resp_seen", 64'(seen), 64'h1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_resp_stable", 64'({bus.resp_v[0], bus.resp_data[DW-1:0]}), {1'b1, 64'h1});
        end
        ch_yumi[0] = 1'b1;
        drain();

        // Watchdog on the short-timeout instance
        rst_wd_n = 1'b1;
        repeat (7) @(negedge clk);
        chk("wd_before_limit", 64'(wd_timeout), 64'h0);
        @(negedge clk);
        chk("wd_at_limit", 64'(wd_timeout), 64'h1);
        repeat (5) @(negedge clk);
        chk("wd_sticky", 64'(wd_timeout), 64'h1);
        chk("main_no_timeout", 64'(timeout), 64'h0);

        // Reset while in DELAY
        issue(0, 40'h05000, 1'b0, '0, 1'b0, '0, 1'b0, -1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_resp_v", 64'(bus.resp_v), 64'h0);
        chk("rst_mid_flags", 64'({en, finish, fail, all_fin, timeout}), 64'h0);
        chk("rst_mid_getchar_ready", 64'(getchar_ready), 64'h1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        issue(1, 40'h05000, 1'b0, '0, 1'b1, 64'h0, 1'b0, 4);
        drain();
        chk("sb_empty", 64'(sb.size()), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
